// File: rtl/ysyx_220053_pkg.sv
// Shared definitions for the instruction fetch queue.
//   XLEN_DEF / ILEN_DEF : default address and instruction widths
//   RESET_PC_DEF        : default first fetch address after reset
//   ifq_entry_t         : one buffered instruction with its PC (default widths)
package ysyx_220053_pkg;

  localparam int unsigned XLEN_DEF     = 64;
  localparam int unsigned ILEN_DEF     = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

  typedef struct packed {
    logic [ILEN_DEF-1:0] instr;
    logic [XLEN_DEF-1:0] pc;
  } ifq_entry_t;

endpackage

// File: rtl/ysyx_220053_sync_fifo.sv
// Synchronous FIFO with flush.
//   clk_i, rst_i        : clock, asynchronous active-high reset (storage cleared)
//   push_i / wdata_i    : write; accepted when not full, or when full and popping
//   pop_i / rdata_o     : read head; rdata_o always shows the head slot
//   flush_i             : empty the FIFO (wins over push/pop)
//   full_o, empty_o, count_o : occupancy
module ysyx_220053_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  import ysyx_220053_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = wdata_i;
        wptr_d        = wptr_q + 1'b1;  // DEPTH is a power of two: natural wrap
      end
      if (do_pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ysyx_220053_ifq.sv
// Instruction fetch queue.
//   req_valid/req_ready/req_addr : sequential fetch requests, at most DEPTH outstanding+buffered
//   resp_valid/resp_data         : in-order doubleword responses, no backpressure
//   out_valid/out_ready/out_*    : in-order instruction delivery to the decoder
//   redirect_valid/redirect_pc   : flush the queue and restart fetch; stale responses dropped
module ysyx_220053_ifq
  import ysyx_220053_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     ILEN     = ILEN_DEF,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [63:0]     resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned   CW      = $clog2(DEPTH+1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   pending_q, pending_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic            issue, keep, deq;
  logic [XLEN-1:0] tag_pc;
  logic [ILEN-1:0] resp_instr;
  logic [CW-1:0]   inst_count, tag_count;
  logic            inst_full, inst_empty, tag_full, tag_empty;
  logic [ILEN+XLEN-1:0] inst_wdata, inst_rdata;
  logic            unused_sigs;

  // Stale in-flight requests still occupy capacity until their responses drain.
  assign req_valid = !rst && !redirect_valid &&
                     (({1'b0, inst_count} + {1'b0, pending_q}) < DEPTH_W);
  assign req_addr  = fetch_pc_q;
  assign issue     = req_valid && req_ready;

  // A response is kept only when no stale responses remain and no redirect is in progress.
  assign keep       = resp_valid && !redirect_valid && (drop_q == '0);
  assign resp_instr = tag_pc[2] ? resp_data[63:32] : resp_data[ILEN-1:0];
  assign inst_wdata = {resp_instr, tag_pc};

  assign out_valid = !inst_empty && !redirect_valid;
  assign deq       = out_valid && out_ready;
  assign out_instr = inst_rdata[ILEN+XLEN-1:XLEN];
  assign out_pc    = inst_rdata[XLEN-1:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pending_d  = pending_q + CW'(issue) - CW'(resp_valid);
    drop_d     = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      // Everything still outstanding after this cycle belongs to the old stream.
      drop_d     = pending_q - CW'(resp_valid);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (resp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      pending_q  <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
    end
  end

  ysyx_220053_sync_fifo #(
    .WIDTH (ILEN + XLEN),
    .DEPTH (DEPTH)
  ) u_inst_q (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (keep),
    .pop_i   (deq),
    .flush_i (redirect_valid),
    .wdata_i (inst_wdata),
    .rdata_o (inst_rdata),
    .full_o  (inst_full),
    .empty_o (inst_empty),
    .count_o (inst_count)
  );

  // PC tags of new-stream requests; stale responses are dropped without popping,
  // since the flush already discarded their tags.
  ysyx_220053_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (issue),
    .pop_i   (keep),
    .flush_i (redirect_valid),
    .wdata_i (fetch_pc_q),
    .rdata_o (tag_pc),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_count)
  );

  assign unused_sigs = ^{redirect_pc[1:0], tag_full, tag_empty, tag_count, inst_full};

  a_no_enq_full: assert property (@(posedge clk) disable iff (rst)
    !(keep && inst_full && !deq));
  a_no_tag_underflow: assert property (@(posedge clk) disable iff (rst)
    !(keep && tag_empty));
  a_tag_matches_live: assert property (@(posedge clk) disable iff (rst)
    tag_count == pending_q - drop_q);

endmodule
